// File: rtl/bcd_countdown_timer_pkg.sv
// Shared helpers for the BCD countdown timer: digit-wise BCD arithmetic and
// the prescaler sizing functions used to derive localparams.
package timer_pkg;

    localparam int MAX_DIGITS = 8;
    localparam int MAX_W      = 4 * MAX_DIGITS;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int calc_cnt_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

    // Digit 0 always decrements; a borrow ripples upward through zero digits,
    // each of which wraps to 9.
    function automatic logic [MAX_W-1:0] bcd_dec(input logic [MAX_W-1:0] v,
                                                 input int digits);
        logic [MAX_W-1:0] r;
        logic             brw;
        logic [3:0]       d;
        r   = v;
        brw = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            d = v[4*i +: 4];
            if (i < digits && brw) begin
                if (d == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = d - 4'd1;
                    brw         = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] bcd_clamp(input logic [MAX_W-1:0] v,
                                                   input int digits);
        logic [MAX_W-1:0] r;
        r = v;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < digits && v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_tick_gen.sv
// Prescaler producing one registered tick every CLK_HZ/TICK_HZ enabled cycles.
// tick_nxt is the wrap condition, letting the count update on the same edge.
module tick_gen
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic tick_nxt
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int CW  = calc_cnt_w(DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_nxt = en && !clr && (cnt_q == CW'(DIV - 1));
        tick_d   = tick_nxt;
        cnt_d    = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick_nxt ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with prescaler, runtime load, pause,
// one-shot / auto-reload terminal behaviour and cascade borrow.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int                    CLK_HZ     = 50000000,
    parameter int                    TICK_HZ    = 1,
    parameter int                    DIGITS     = 2,
    parameter logic [4*DIGITS-1:0]   PRESET_BCD = 'h59
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cnt_en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  auto_reload,
    output logic [4*DIGITS-1:0]   x,
    output logic                  borrow,
    output logic                  tick,
    output logic                  done
);

    localparam int W = 4 * DIGITS;

    logic         tick_nxt;
    logic         tick_en;
    logic [W-1:0] x_q, x_d;
    logic         borrow_q, borrow_d;
    logic         done_q, done_d;

    // An expired one-shot freezes the prescaler until load or reset.
    assign tick_en = cnt_en && !done_q;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (tick_en),
        .clr      (load),
        .tick     (tick),
        .tick_nxt (tick_nxt)
    );

    always_comb begin
        x_d      = x_q;
        borrow_d = 1'b0;
        done_d   = done_q;
        if (load) begin
            x_d    = W'(bcd_clamp(MAX_W'(load_val), DIGITS));
            done_d = 1'b0;
        end else if (tick_nxt) begin
            if (x_q == '0) begin
                borrow_d = 1'b1;
                if (auto_reload) begin
                    x_d = PRESET_BCD;
                end else begin
                    done_d = 1'b1;
                end
            end else begin
                x_d = W'(bcd_dec(MAX_W'(x_q), DIGITS));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q      <= PRESET_BCD;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            x_q      <= x_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign x      = x_q;
    assign borrow = borrow_q;
    assign done   = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: decimal-integer reference model compared every
// cycle, plus directed sequences with literal expectations.
module tb_bcd_countdown_timer;

    localparam int DIV = 10;

    typedef struct {
        int   val;
        int   ph;
        logic tk;
        logic bo;
        logic dn;
    } mst_t;

    logic        clk = 1'b0;
    logic        rst, cnt_en, load, auto_reload;
    logic [7:0]  load_val;
    logic [7:0]  x;
    logic        borrow, tick, done;

    logic        rst3, en3, load3, ar3;
    logic [11:0] lv3;
    logic [11:0] x3;
    logic        borrow3, tick3, done3;

    int   checks = 0;
    int   errors = 0;
    logic b_done = 1'b0;
    mst_t ma, mb;

    always #5 clk = ~clk;

    bcd_countdown_timer #(
        .CLK_HZ(10), .TICK_HZ(1), .DIGITS(2), .PRESET_BCD(8'h59)
    ) dut_a (
        .clk(clk), .rst(rst), .cnt_en(cnt_en), .load(load), .load_val(load_val),
        .auto_reload(auto_reload), .x(x), .borrow(borrow), .tick(tick), .done(done)
    );

    bcd_countdown_timer #(
        .CLK_HZ(10), .TICK_HZ(1), .DIGITS(3), .PRESET_BCD(12'h100)
    ) dut_b (
        .clk(clk), .rst(rst3), .cnt_en(en3), .load(load3), .load_val(lv3),
        .auto_reload(ar3), .x(x3), .borrow(borrow3), .tick(tick3), .done(done3)
    );

    function automatic logic [31:0] int2bcd(input int v, input int nd);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int bcd2int_clamped(input logic [31:0] v, input int nd);
        int s, p, d;
        s = 0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            s = s + d * p;
            p = p * 10;
        end
        return s;
    endfunction

    function automatic mst_t mnext(input mst_t s, input int pre, input logic l,
                                   input int lval, input logic en, input logic ar);
        mst_t n;
        n    = s;
        n.tk = 1'b0;
        n.bo = 1'b0;
        if (l) begin
            n.val = lval;
            n.ph  = 0;
            n.dn  = 1'b0;
        end else if (en && !s.dn) begin
            if (s.ph == DIV - 1) begin
                n.ph = 0;
                n.tk = 1'b1;
                if (s.val == 0) begin
                    n.bo = 1'b1;
                    if (ar) n.val = pre;
                    else    n.dn  = 1'b1;
                end else begin
                    n.val = s.val - 1;
                end
            end else begin
                n.ph = s.ph + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) ma <= '{val: 59, ph: 0, tk: 1'b0, bo: 1'b0, dn: 1'b0};
        else     ma <= mnext(ma, 59, load, bcd2int_clamped(32'(load_val), 2), cnt_en, auto_reload);
    end

    always @(posedge clk or posedge rst3) begin
        if (rst3) mb <= '{val: 100, ph: 0, tk: 1'b0, bo: 1'b0, dn: 1'b0};
        else      mb <= mnext(mb, 100, load3, bcd2int_clamped(32'(lv3), 3), en3, ar3);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("a_x",      32'(x),      int2bcd(ma.val, 2));
            chk("a_tick",   32'(tick),   32'(ma.tk));
            chk("a_borrow", 32'(borrow), 32'(ma.bo));
            chk("a_done",   32'(done),   32'(ma.dn));
        end
        if (!rst3) begin
            chk("b_x",      32'(x3),      int2bcd(mb.val, 3));
            chk("b_tick",   32'(tick3),   32'(mb.tk));
            chk("b_borrow", 32'(borrow3), 32'(mb.bo));
            chk("b_done",   32'(done3),   32'(mb.dn));
        end
    end

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 100);
        if (!tick) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout actual=none required=tick within 100 cycles");
        end
    endtask

    initial begin
        int n, cnt;
        rst = 1'b1; rst3 = 1'b1; cnt_en = 1'b0; en3 = 1'b0;
        load = 1'b0; load_val = '0; auto_reload = 1'b1;
        load3 = 1'b0; lv3 = '0; ar3 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_x", 32'(x), 32'h59);
        chk("rst_borrow", 32'(borrow), 0);
        chk("rst_tick", 32'(tick), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_b_x", 32'(x3), 32'h100);
        rst = 1'b0; rst3 = 1'b0; cnt_en = 1'b1; en3 = 1'b1;

        // Full 60-tick wrap with auto-reload.
        for (int t = 1; t <= 60; t++) begin
            wait_tick(n);
            chk("tick_gap", 32'(n), 10);
            chk("borrow_at_tick", 32'(borrow), 32'(t == 60));
            if (t < 60) chk("x_step", 32'(x), int2bcd(59 - t, 2));
            if (t == 1)  chk("x_first", 32'(x), 32'h58);
            if (t == 40) chk("x_20_to_19", 32'(x), 32'h19);
            if (t == 50) chk("x_10_to_09", 32'(x), 32'h09);
            if (t == 60) chk("x_reload", 32'(x), 32'h59);
        end

        // One-shot expiry.
        auto_reload = 1'b0; load = 1'b1; load_val = 8'h02;
        @(negedge clk);
        load = 1'b0;
        chk("load_x", 32'(x), 32'h02);
        wait_tick(n); chk("os_gap", 32'(n), 10); chk("os_x1", 32'(x), 32'h01);
        wait_tick(n); chk("os_x0", 32'(x), 32'h00); chk("os_done_early", 32'(done), 0);
        wait_tick(n);
        chk("os_borrow", 32'(borrow), 1);
        chk("os_done", 32'(done), 1);
        chk("os_hold", 32'(x), 32'h00);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (tick) cnt++;
        end
        chk("no_tick_after_done", 32'(cnt), 0);
        load = 1'b1; load_val = 8'h05;
        @(negedge clk);
        load = 1'b0;
        chk("reload_done_clr", 32'(done), 0);
        chk("reload_x", 32'(x), 32'h05);
        wait_tick(n); chk("resume_gap", 32'(n), 10); chk("resume_x", 32'(x), 32'h04);

        // Pause four cycles into a prescaler period.
        repeat (4) @(negedge clk);
        cnt_en = 1'b0;
        repeat (25) @(negedge clk);
        chk("pause_x", 32'(x), 32'h04);
        cnt_en = 1'b1;
        wait_tick(n);
        chk("pause_gap", 32'(n), 6);
        chk("pause_x_after", 32'(x), 32'h03);

        // Load on the wrap cycle discards the tick.
        repeat (9) @(negedge clk);
        load = 1'b1; load_val = 8'h33;
        @(negedge clk);
        load = 1'b0;
        chk("ld_tick_x", 32'(x), 32'h33);
        chk("ld_tick_borrow", 32'(borrow), 0);
        chk("ld_tick_tick", 32'(tick), 0);
        wait_tick(n); chk("ld_tick_gap", 32'(n), 10); chk("ld_tick_x2", 32'(x), 32'h32);
        load = 1'b1; load_val = 8'hAF;
        @(negedge clk);
        load = 1'b0;
        chk("clamp_x", 32'(x), 32'h99);

        // Asynchronous reset mid-count.
        auto_reload = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_x", 32'(x), 32'h59);
        chk("arst_done", 32'(done), 0);
        chk("arst_borrow", 32'(borrow), 0);
        chk("arst_tick", 32'(tick), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_tick(n); chk("arst_gap", 32'(n), 10); chk("arst_x2", 32'(x), 32'h58);

        n = 0;
        while (!b_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!b_done) begin
            checks++;
            errors++;
            $display("FAIL b_timeout actual=unfinished required=101 ticks");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Three-digit instance: 100 -> 099 -> 098, borrow on tick 101.
    initial begin
        int n;
        @(negedge clk);
        while (rst3) @(negedge clk);
        for (int k = 1; k <= 101; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!tick3 && n < 20);
            if (!tick3) begin
                checks++;
                errors++;
                $display("FAIL b_tick_timeout actual=none required=tick k=%0d", k);
                break;
            end
            chk("b_borrow_k", 32'(borrow3), 32'(k == 101));
            if (k == 1)   chk("b_x_099", 32'(x3), 32'h099);
            if (k == 2)   chk("b_x_098", 32'(x3), 32'h098);
            if (k == 100) chk("b_x_000", 32'(x3), 32'h000);
            if (k == 101) chk("b_x_reload", 32'(x3), 32'h100);
        end
        b_done = 1'b1;
    end

endmodule
